// File: rtl/clangpu_axi_mem.sv
// AXI4 slave memory: word-addressed RAM with independent write and read
// channel FSMs, INCR bursts, byte strobes and SLVERR on out-of-range beats.
module clangpu_axi_mem #(
    parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_MEM_WORDS        = 1024
) (
    input  logic                            CCLK,
    input  logic                            CRST,
    // write address channel
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    // write response channel
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    // read address channel
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    // read data channel
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int unsigned IDX_W  = $clog2(C_MEM_WORDS);
    localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_WORDS];

    // a beat is in range when its word address lies below the RAM depth
    function automatic logic in_range(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
        return (a >> (2 + IDX_W)) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
        return a[2 +: IDX_W];
    endfunction

    // WLAST is deliberately ignored: the latched beat count ends the burst
    logic unused_wlast;
    assign unused_wlast = S_AXI_WLAST;

    // ---------------------------------------------------------------
    // write channel
    // ---------------------------------------------------------------
    wstate_t                        w_state, w_next;
    logic [C_S_AXI_ID_WIDTH-1:0]    w_id;
    logic [C_S_AXI_ADDR_WIDTH-1:0]  w_addr;
    logic [7:0]                     w_cnt;
    logic                           w_err;
    logic                           aw_ready, w_ready, b_valid;
    logic                           aw_fire, w_fire;

    // write FSM state register
    always_ff @(posedge CCLK or posedge CRST) begin
        if (CRST) w_state <= W_IDLE;
        else      w_state <= w_next;
    end

    // write FSM next state and handshake outputs
    always_comb begin
        w_next   = w_state;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                aw_ready = 1'b1;
                if (S_AXI_AWVALID) w_next = W_DATA;
            end
            W_DATA: begin
                w_ready = 1'b1;
                if (S_AXI_WVALID && w_cnt == '0) w_next = W_RESP;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign aw_fire = aw_ready && S_AXI_AWVALID;
    assign w_fire  = w_ready && S_AXI_WVALID;

    // write burst bookkeeping: ID, running address, beats left, error flag
    always_ff @(posedge CCLK or posedge CRST) begin
        if (CRST) begin
            w_id   <= '0;
            w_addr <= '0;
            w_cnt  <= '0;
            w_err  <= 1'b0;
        end else if (aw_fire) begin
            w_id   <= S_AXI_AWID;
            w_addr <= S_AXI_AWADDR;
            w_cnt  <= S_AXI_AWLEN;
            w_err  <= 1'b0;
        end else if (w_fire) begin
            w_addr <= w_addr + C_S_AXI_ADDR_WIDTH'(4);
            if (w_cnt != '0)       w_cnt <= w_cnt - 8'd1;
            if (!in_range(w_addr)) w_err <= 1'b1;
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BID     = b_valid ? w_id : '0;
    assign S_AXI_BRESP   = (b_valid && w_err) ? 2'b10 : 2'b00;

    // ---------------------------------------------------------------
    // read channel
    // ---------------------------------------------------------------
    rstate_t                        r_state, r_next;
    logic [C_S_AXI_ID_WIDTH-1:0]    r_id;
    logic [C_S_AXI_ADDR_WIDTH-1:0]  r_addr;
    logic [C_S_AXI_ADDR_WIDTH-1:0]  r_addr_inc;
    logic [C_S_AXI_ADDR_WIDTH-1:0]  r_fetch_addr;
    logic [7:0]                     r_cnt;
    logic                           r_last;
    logic                           r_ok;
    logic [C_S_AXI_DATA_WIDTH-1:0]  r_word;
    logic                           ar_ready, r_valid;
    logic                           ar_fire, r_fire, r_adv, r_load;

    // read FSM state register
    always_ff @(posedge CCLK or posedge CRST) begin
        if (CRST) r_state <= R_IDLE;
        else      r_state <= r_next;
    end

    // read FSM next state and handshake outputs
    always_comb begin
        r_next   = r_state;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (S_AXI_ARVALID) r_next = R_DATA;
            end
            R_DATA: begin
                r_valid = 1'b1;
                if (S_AXI_RREADY && r_cnt == '0) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_fire    = ar_ready && S_AXI_ARVALID;
    assign r_fire     = r_valid && S_AXI_RREADY;
    assign r_adv      = r_fire && (r_cnt != '0);
    assign r_addr_inc = r_addr + C_S_AXI_ADDR_WIDTH'(4);
    // the RAM is read on the same edge that accepts AR or a beat, so the
    // next beat's word is already registered when RVALID is presented
    assign r_fetch_addr = ar_fire ? S_AXI_ARADDR : r_addr_inc;
    assign r_load       = ar_fire || r_adv;

    // read burst bookkeeping: ID, current beat address, beats left, status
    always_ff @(posedge CCLK or posedge CRST) begin
        if (CRST) begin
            r_id   <= '0;
            r_addr <= '0;
            r_cnt  <= '0;
            r_last <= 1'b0;
            r_ok   <= 1'b0;
        end else if (ar_fire) begin
            r_id   <= S_AXI_ARID;
            r_addr <= S_AXI_ARADDR;
            r_cnt  <= S_AXI_ARLEN;
            r_last <= (S_AXI_ARLEN == '0);
            r_ok   <= in_range(S_AXI_ARADDR);
        end else if (r_adv) begin
            r_addr <= r_addr_inc;
            r_cnt  <= r_cnt - 8'd1;
            r_last <= (r_cnt == 8'd1);
            r_ok   <= in_range(r_addr_inc);
        end
    end

    // RAM: strobed byte writes and registered read; the read samples the
    // pre-write contents so a same-word collision returns old data
    always_ff @(posedge CCLK) begin
        if (w_fire && in_range(w_addr)) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
        if (r_load) r_word <= mem[word_idx(r_fetch_addr)];
    end

    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RID     = r_valid ? r_id : '0;
    assign S_AXI_RDATA   = (r_valid && r_ok) ? r_word : '0;
    assign S_AXI_RRESP   = (r_valid && !r_ok) ? 2'b10 : 2'b00;
    assign S_AXI_RLAST   = r_valid && r_last;

endmodule
